// File: rtl/cla_seq_addsub_if.sv
// Handshake and operand/result bundle for the sequential carry-lookahead
// adder/subtractor. The requester drives the master side, the adder is the slave.
interface cla_seq_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             z;
  logic             busy;
  logic             done;

  modport master (
    output start, op, ci, a, b,
    input  s, co, ov, z, busy, done
  );

  modport slave (
    input  start, op, ci, a, b,
    output s, co, ov, z, busy, done
  );
endinterface

// File: rtl/cla_seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. A single 4-bit carry-lookahead group
// is reused once per clock, low nibble first. The operand registers shift right
// by 4 each cycle, and the partial sum shifts in from the top. After N = WIDTH/4
// cycles the partial register holds the full sum in bit order.
module cla_seq_addsub #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  cla_seq_addsub_if.slave bus
);

  localparam int N  = WIDTH / 4;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(N - 1);
  localparam logic [GW-1:0] G_ONE  = GW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;
  logic             last_s;
  logic [GW-1:0]    g_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] part_r;
  logic [WIDTH-1:0] s_r;
  logic             co_r;
  logic             ov_r;
  logic             z_r;
  logic             busy_r;
  logic             done_r;
  logic [5:0]       grp_s;
  logic             c3_s;
  logic             cout_s;
  logic [3:0]       sum4_s;
  logic [WIDTH-1:0] sum_full_s;

  // 4-bit carry-lookahead group: returns {carry into bit 3, carry out, sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  // Next-state logic: accept a request in IDLE, leave RUN after the last group.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (g_r == G_LAST) begin
          state_nx_s = ST_IDLE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Current group: low nibble of the shifting operands with the running carry.
  always_comb begin
    grp_s                  = cla4(a_r[3:0], b_r[3:0], carry_r);
    {c3_s, cout_s, sum4_s} = grp_s;
    sum_full_s             = {sum4_s, part_r[WIDTH-1:4]};
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == ST_RUN);
    end
  end

  // Datapath: latch effective operands on accept, step one group per RUN cycle,
  // and update the result registers only on the completion edge. In the last
  // group, c3 is the carry into the MSB, so overflow uses it directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_r     <= {GW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      part_r  <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      co_r    <= 1'b0;
      ov_r    <= 1'b0;
      z_r     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        a_r     <= bus.a;
        b_r     <= bus.op ? ~bus.b : bus.b;
        carry_r <= bus.op | bus.ci;
        g_r     <= {GW{1'b0}};
        part_r  <= {WIDTH{1'b0}};
      end else if (state_r == ST_RUN) begin
        a_r     <= a_r >> 4;
        b_r     <= b_r >> 4;
        carry_r <= cout_s;
        part_r  <= sum_full_s;
        g_r     <= last_s ? {GW{1'b0}} : (g_r + G_ONE);
        if (last_s) begin
          s_r  <= sum_full_s;
          co_r <= cout_s;
          ov_r <= c3_s ^ cout_s;
          z_r  <= (sum_full_s == {WIDTH{1'b0}});
        end
      end
    end
  end

  assign bus.s    = s_r;
  assign bus.co   = co_r;
  assign bus.ov   = ov_r;
  assign bus.z    = z_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Directed and random bench for cla_seq_addsub: an 8-bit instance for the
// corner cases and handshake, and a 32-bit instance for a back-to-back random
// stream and reset-abort behaviour. Expected results go into per-instance
// queues when a request is issued and are popped when done pulses.
module tb_cla_seq_addsub;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  logic clk;
  logic rst8_n;
  logic rst32_n;
  int   compared;
  int   mismatched;
  exp_t q8[$];
  exp_t q32[$];

  cla_seq_addsub_if #(.WIDTH(8))  bus8 ();
  cla_seq_addsub_if #(.WIDTH(32)) bus32 ();

  cla_seq_addsub #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(rst8_n),  .bus(bus8.slave));
  cla_seq_addsub #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(rst32_n), .bus(bus32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 33 bits, mask to w, derive overflow from operand signs.
  function automatic exp_t ref_model(input int w, input logic op, input logic ci,
                                     input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] bm;
    logic [32:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = a & mask;
    bm   = (op ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + {32'h0, (op ? 1'b1 : ci)};
    e.s  = full[31:0] & mask;
    e.co = full[w];
    e.ov = (am[w-1] == bm[w-1]) && (e.s[w-1] != am[w-1]);
    e.z  = (e.s == 32'h0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic co, input logic ov,
                              input logic z);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov; e.z = z;
    return e;
  endfunction

  // Drive a request just after a falling edge; drop start at the next falling edge.
  task automatic issue(input bit wide, input logic op, input logic ci,
                       input logic [31:0] a, input logic [31:0] b);
    if (wide) begin
      bus32.start = 1'b1; bus32.op = op; bus32.ci = ci; bus32.a = a; bus32.b = b;
    end else begin
      bus8.start = 1'b1; bus8.op = op; bus8.ci = ci; bus8.a = a[7:0]; bus8.b = b[7:0];
    end
    @(negedge clk);
    bus8.start  = 1'b0;
    bus32.start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles and busy cycles from the current sample.
  task automatic wait_done(input bit wide, input string tag, output int lat, output int bc);
    logic d;
    lat = 0;
    bc  = (wide ? bus32.busy : bus8.busy) ? 1 : 0;
    d   = wide ? bus32.done : bus8.done;
    while (d !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if ((wide ? bus32.busy : bus8.busy) === 1'b1) bc++;
      d = wide ? bus32.done : bus8.done;
    end
    check({tag, "_done_seen"}, {31'h0, d}, 32'h1);
  endtask

  // Pop the oldest expectation for one instance and compare the result outputs.
  task automatic cmp(input bit wide, input string tag);
    exp_t e;
    if ((wide ? q32.size() : q8.size()) == 0) begin
      check({tag, "_queue_empty"}, 32'h0, 32'h1);
    end else begin
      e = wide ? q32.pop_front() : q8.pop_front();
      check({tag, "_s"},  wide ? bus32.s : {24'h0, bus8.s}, e.s);
      check({tag, "_co"}, {31'h0, wide ? bus32.co : bus8.co}, {31'h0, e.co});
      check({tag, "_ov"}, {31'h0, wide ? bus32.ov : bus8.ov}, {31'h0, e.ov});
      check({tag, "_z"},  {31'h0, wide ? bus32.z : bus8.z},   {31'h0, e.z});
    end
  endtask

  initial begin
    int          lat;
    int          bc;
    int          issued;
    int          retired;
    int          cyc;
    int          last_cyc;
    int          dcount;
    logic [31:0] held_s;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;
    logic        rci;

    compared   = 0;
    mismatched = 0;
    bus8.start  = 1'b0; bus8.op  = 1'b0; bus8.ci  = 1'b0; bus8.a  = 8'h0;  bus8.b  = 8'h0;
    bus32.start = 1'b0; bus32.op = 1'b0; bus32.ci = 1'b0; bus32.a = 32'h0; bus32.b = 32'h0;
    rst8_n  = 1'b0;
    rst32_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst8_s",     {24'h0, bus8.s},     32'h0);
    check("rst8_co",    {31'h0, bus8.co},    32'h0);
    check("rst8_ov",    {31'h0, bus8.ov},    32'h0);
    check("rst8_z",     {31'h0, bus8.z},     32'h0);
    check("rst8_busy",  {31'h0, bus8.busy},  32'h0);
    check("rst8_done",  {31'h0, bus8.done},  32'h0);
    check("rst32_s",    bus32.s,             32'h0);
    check("rst32_busy", {31'h0, bus32.busy}, 32'h0);
    rst8_n  = 1'b1;
    rst32_n = 1'b1;
    @(negedge clk);

    // 8-bit directed corners: latency 2, busy for 2 cycles
    q8.push_back(mk(32'h80, 1'b1 ^ 1'b1, 1'b1, 1'b0));
    issue(1'b0, 1'b0, 1'b0, 32'h7F, 32'h01);
    wait_done(1'b0, "add_7f_01", lat, bc);
    check("add_7f_01_latency", lat, 32'd2);
    check("add_7f_01_busy_cycles", bc, 32'd2);
    cmp(1'b0, "add_7f_01");

    q8.push_back(mk(32'h00, 1'b1, 1'b0, 1'b1));
    issue(1'b0, 1'b0, 1'b0, 32'hFF, 32'h01);
    wait_done(1'b0, "add_ff_01", lat, bc);
    cmp(1'b0, "add_ff_01");

    q8.push_back(mk(32'h00, 1'b1, 1'b0, 1'b1));
    issue(1'b0, 1'b0, 1'b1, 32'hFE, 32'h01);
    wait_done(1'b0, "add_fe_01_ci", lat, bc);
    cmp(1'b0, "add_fe_01_ci");

    q8.push_back(mk(32'h7F, 1'b1, 1'b1, 1'b0));
    issue(1'b0, 1'b1, 1'b1, 32'h80, 32'h01);
    wait_done(1'b0, "sub_80_01", lat, bc);
    cmp(1'b0, "sub_80_01");

    q8.push_back(mk(32'hFF, 1'b0, 1'b0, 1'b0));
    issue(1'b0, 1'b1, 1'b0, 32'h00, 32'h01);
    wait_done(1'b0, "sub_00_01", lat, bc);
    cmp(1'b0, "sub_00_01");

    // start while busy is ignored; start in the done cycle is accepted
    q8.push_back(mk(32'h30, 1'b0, 1'b0, 1'b0));
    issue(1'b0, 1'b0, 1'b0, 32'h10, 32'h20);
    issue(1'b0, 1'b1, 1'b1, 32'h55, 32'h11);
    wait_done(1'b0, "busy_ignore", lat, bc);
    cmp(1'b0, "busy_ignore");
    q8.push_back(mk(32'h77, 1'b0, 1'b0, 1'b0));
    issue(1'b0, 1'b0, 1'b0, 32'h33, 32'h44);
    check("hold_during_run", {24'h0, bus8.s}, 32'h30);
    wait_done(1'b0, "done_cycle_start", lat, bc);
    check("done_cycle_start_latency", lat, 32'd2);
    cmp(1'b0, "done_cycle_start");
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus8.done === 1'b1) dcount++;
    end
    check("no_extra_done8", dcount, 32'd0);

    // 32-bit back-to-back random stream; a start in every done cycle gives
    // one completion every N+1 clocks
    issued   = 0;
    retired  = 0;
    cyc      = 0;
    last_cyc = -1;
    held_s   = 32'h0;
    ra = $urandom; rb = $urandom; rop = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
    q32.push_back(ref_model(32, rop, rci, ra, rb));
    bus32.start = 1'b1; bus32.op = rop; bus32.ci = rci; bus32.a = ra; bus32.b = rb;
    issued = 1;
    while (retired < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus32.start = 1'b0;
      if (bus32.done === 1'b1) begin
        cmp(1'b1, "stream");
        if (last_cyc >= 0) check("stream_interval", cyc - last_cyc, 32'd9);
        last_cyc = cyc;
        held_s   = bus32.s;
        retired++;
        if (issued < 1000) begin
          ra = $urandom; rb = $urandom;
          rop = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
          q32.push_back(ref_model(32, rop, rci, ra, rb));
          bus32.start = 1'b1; bus32.op = rop; bus32.ci = rci; bus32.a = ra; bus32.b = rb;
          issued++;
        end
      end else if (retired > 0) begin
        check("stream_s_hold", bus32.s, held_s);
      end
    end
    check("stream_retired", retired, 32'd1000);

    // Known non-zero result, then reset in the middle of the next run
    @(negedge clk);
    q32.push_back(mk(32'h1234_5679, 1'b0, 1'b0, 1'b0));
    issue(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0001);
    wait_done(1'b1, "add32_plain", lat, bc);
    check("add32_plain_latency", lat, 32'd8);
    check("add32_plain_busy_cycles", bc, 32'd8);
    cmp(1'b1, "add32_plain");
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b1, 32'h8000_0001, 32'h8000_0001);
    repeat (3) @(negedge clk);
    check("pre_abort_busy", {31'h0, bus32.busy}, 32'h1);
    rst32_n = 1'b0;
    #1;
    check("abort_s",    bus32.s,             32'h0);
    check("abort_co",   {31'h0, bus32.co},   32'h0);
    check("abort_ov",   {31'h0, bus32.ov},   32'h0);
    check("abort_z",    {31'h0, bus32.z},    32'h0);
    check("abort_busy", {31'h0, bus32.busy}, 32'h0);
    check("abort_done", {31'h0, bus32.done}, 32'h0);
    repeat (2) @(negedge clk);
    rst32_n = 1'b1;
    dcount  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus32.done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);

    q32.push_back(mk(32'h0, 1'b1, 1'b0, 1'b1));
    issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(1'b1, "post_reset_add", lat, bc);
    check("post_reset_add_latency", lat, 32'd8);
    cmp(1'b1, "post_reset_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
